// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer
//   Serialises a 16-lane vector load or store from the MEM stage onto a
//   single-lane memory port, one lane per memory handshake, and freezes the
//   upstream pipeline while the access is in flight.
//
// Ports
//   CLK, RST            clock; synchronous active-high reset
//   MemWriteM           MEM-stage instruction is a vector store
//   MemtoRegM           MEM-stage instruction is a vector load
//   ALUResultM[16xN]    lane 0 carries the base word address
//   writeDataM[16xN]    store data, lane 0 in the low N bits
//   mem_rdata[N]        read data, valid with mem_ack
//   mem_ack             memory completes the current access this cycle
//   mem_req/mem_we      access request / write enable
//   mem_addr[AW]        word address of the current access
//   mem_wdata[N]        write data of the current access
//   RDM[16xN]           assembled load vector, lane 0 in the low N bits
//   StallM              freezes fetch/decode/execute/MEM registers
//   done                one-cycle completion pulse
module vector_mem_sequencer #(
    parameter int N  = 16,
    parameter int AW = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            MemWriteM,
    input  logic            MemtoRegM,
    input  logic [16*N-1:0] ALUResultM,
    input  logic [16*N-1:0] writeDataM,
    input  logic [N-1:0]    mem_rdata,
    input  logic            mem_ack,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [N-1:0]    mem_wdata,
    output logic [16*N-1:0] RDM,
    output logic            StallM,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      lane;
    logic [3:0]      lane_inc;
    logic            op_we;
    logic [16*N-1:0] snap;
    logic [AW-1:0]   addr_r;
    logic [N-1:0]    wdata_r;
    logic            start;
    logic            last_lane;
    logic            req_c;
    logic            we_c;
    logic            done_c;

    // Zero-extend (or truncate) an N-bit lane value to an AW-bit address.
    function automatic logic [AW-1:0] zext_addr(input logic [N-1:0] v);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (i < AW) r[i] = v[i];
        end
        return r;
    endfunction

    assign start     = MemWriteM | MemtoRegM;
    assign last_lane = (lane == 4'hF);
    assign lane_inc  = lane + 4'd1;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_c     = 1'b0;
        we_c      = 1'b0;
        StallM    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    StallM    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                req_c  = 1'b1;
                we_c   = op_we;
                StallM = 1'b1;
                if (mem_ack && last_lane) state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-port outputs are forced quiet during reset so the port is
    // idle in the reset cycle itself, not only after the edge.
    assign mem_req   = req_c  & ~RST;
    assign mem_we    = we_c   & ~RST;
    assign done      = done_c & ~RST;
    assign mem_addr  = RST ? '0 : addr_r;
    assign mem_wdata = RST ? '0 : wdata_r;

    // addr_r/wdata_r always hold the current lane's address and data, so
    // they stay stable while waiting for ack and keep their last values
    // once the access completes. addr_r + 1 wraps modulo 2^AW.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lane    <= '0;
            op_we   <= 1'b0;
            snap    <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            RDM     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lane    <= '0;
                        op_we   <= MemWriteM;
                        snap    <= writeDataM;
                        addr_r  <= zext_addr(ALUResultM[N-1:0]);
                        wdata_r <= writeDataM[N-1:0];
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (!op_we) RDM[int'(lane)*N +: N] <= mem_rdata;
                        if (!last_lane) begin
                            lane    <= lane_inc;
                            addr_r  <= addr_r + AW'(1);
                            wdata_r <= snap[int'(lane_inc)*N +: N];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
module tb_vector_mem_sequencer;

    localparam int N  = 32;
    localparam int AW = 32;

    logic            CLK;
    logic            RST;
    logic            MemWriteM;
    logic            MemtoRegM;
    logic [16*N-1:0] ALUResultM;
    logic [16*N-1:0] writeDataM;
    logic [N-1:0]    mem_rdata;
    logic            mem_ack;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [N-1:0]    mem_wdata;
    logic [16*N-1:0] RDM;
    logic            StallM;
    logic            done;

    vector_mem_sequencer #(.N(N), .AW(AW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .ALUResultM (ALUResultM),
        .writeDataM (writeDataM),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .RDM        (RDM),
        .StallM     (StallM),
        .done       (done)
    );

    // Memory model: every word reads back as its address plus 0x100.
    assign mem_rdata = mem_addr + 32'h100;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t        expq[$];
    logic [31:0] rdm_exp[16];
    int          n_chk;
    int          n_fail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete vector access. Entered and left just after a falling edge.
    task automatic run_vec(input logic we, input logic ld, input logic [31:0] base,
                           input logic [31:0] dbase, input int period, input bit hold);
        int          reqc;
        int          stallc;
        int          guard;
        int          li;
        acc_t        e;
        logic [31:0] last;
        last = base + 32'd15;
        for (int i = 0; i < 16; i++) begin
            writeDataM[i*N +: N] = dbase + 32'(i);
            ALUResultM[i*N +: N] = (i == 0) ? base : 32'hDEAD0000 + 32'(i);
            e.we   = we;
            e.addr = base + 32'(i);
            e.data = dbase + 32'(i);
            expq.push_back(e);
        end
        MemWriteM = we;
        MemtoRegM = ld;
        mem_ack   = 1'b1;
        #1;
        chk("start_stall", 64'(StallM), 64'd1);
        chk("start_req", 64'(mem_req), 64'd0);
        chk("start_done", 64'(done), 64'd0);
        stallc = 1;
        @(negedge CLK);
        if (!hold) begin
            MemWriteM = 1'b0;
            MemtoRegM = 1'b0;
        end
        reqc  = 0;
        guard = 0;
        while (expq.size() > 0 && guard < 200) begin
            mem_ack = ((reqc % period) == period - 1);
            #1;
            chk("req", 64'(mem_req), 64'd1);
            chk("req_stall", 64'(StallM), 64'd1);
            chk("req_done", 64'(done), 64'd0);
            e = expq[0];
            chk("we", 64'(mem_we), 64'(e.we));
            chk("addr", 64'(mem_addr), 64'(e.addr));
            if (e.we) chk("wdata", 64'(mem_wdata), 64'(e.data));
            if (StallM) stallc++;
            if (mem_ack && mem_req) begin
                li = 16 - expq.size();
                if (!e.we) rdm_exp[li] = e.addr + 32'h100;
                void'(expq.pop_front());
            end
            reqc++;
            guard++;
            @(negedge CLK);
        end
        chk("req_timeout", 64'(guard < 200), 64'd1);
        if (period == 1) begin
            chk("req_cycles", 64'(reqc), 64'd16);
            chk("stall_cycles", 64'(stallc), 64'd17);
        end
        mem_ack = 1'b1;
        #1;
        chk("done", 64'(done), 64'd1);
        chk("done_req", 64'(mem_req), 64'd0);
        chk("done_we", 64'(mem_we), 64'd0);
        chk("done_stall", 64'(StallM), 64'd0);
        chk("done_addr_hold", 64'(mem_addr), 64'(last));
        @(negedge CLK);
        mem_ack = 1'b0;
        for (int i = 0; i < 16; i++) chk("rdm", 64'(RDM[i*N +: N]), 64'(rdm_exp[i]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        RST        = 1'b1;
        MemWriteM  = 1'b0;
        MemtoRegM  = 1'b0;
        ALUResultM = '0;
        writeDataM = '0;
        mem_ack    = 1'b0;
        for (int i = 0; i < 16; i++) rdm_exp[i] = '0;

        // Reset state, during and just after reset
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            #1;
            chk("rst_req", 64'(mem_req), 64'd0);
            chk("rst_we", 64'(mem_we), 64'd0);
            chk("rst_addr", 64'(mem_addr), 64'd0);
            chk("rst_wdata", 64'(mem_wdata), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
        end
        RST = 1'b0;
        @(negedge CLK);
        #1;
        chk("post_rst_req", 64'(mem_req), 64'd0);
        chk("post_rst_addr", 64'(mem_addr), 64'd0);
        chk("post_rst_wdata", 64'(mem_wdata), 64'd0);
        chk("post_rst_done", 64'(done), 64'd0);
        chk("post_rst_stall", 64'(StallM), 64'd0);
        chk("post_rst_rdm", 64'(RDM == '0), 64'd1);
        @(negedge CLK);

        // Load, ack tied high, base 0x10
        run_vec(1'b0, 1'b1, 32'h10, 32'h5555_0000, 1, 1'b0);
        // Store, ack every third cycle; RDM must keep the load result
        run_vec(1'b1, 1'b0, 32'h300, 32'hA000, 3, 1'b0);
        // Both load and store flags: treated as a store
        run_vec(1'b1, 1'b1, 32'h400, 32'hB000, 2, 1'b0);
        // Address wrap past 2^32
        run_vec(1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0, 1, 1'b0);
        // Start held through DONE; next access begins in the following IDLE cycle
        run_vec(1'b0, 1'b1, 32'h40, 32'h0, 1, 1'b1);
        run_vec(1'b0, 1'b1, 32'h80, 32'h0, 1, 1'b0);

        // Reset at lane 5 of a load
        ALUResultM[N-1:0] = 32'h200;
        MemtoRegM = 1'b1;
        mem_ack   = 1'b1;
        @(negedge CLK);
        MemtoRegM = 1'b0;
        for (int c = 0; c < 5; c++) @(negedge CLK);
        #1;
        chk("lane5_addr", 64'(mem_addr), 64'h205);
        RST = 1'b1;
        #1;
        chk("rst_mid_req", 64'(mem_req), 64'd0);
        @(negedge CLK);
        RST     = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 16; i++) rdm_exp[i] = '0;
        expq.delete();
        #1;
        chk("abort_req", 64'(mem_req), 64'd0);
        chk("abort_stall", 64'(StallM), 64'd0);
        chk("abort_addr", 64'(mem_addr), 64'd0);
        chk("abort_wdata", 64'(mem_wdata), 64'd0);
        chk("abort_rdm", 64'(RDM == '0), 64'd1);
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("abort_no_done", 64'(done), 64'd0);
            chk("abort_no_req", 64'(mem_req), 64'd0);
            @(negedge CLK);
        end
        mem_ack = 1'b0;

        // Recovery after the aborted access
        run_vec(1'b0, 1'b1, 32'h1000, 32'h0, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
